// File: rtl/demux7_deserializer_if.sv
// Serial-in / parallel-out signal bundle for demux7_deserializer.
// master drives the serial side; slave is the deserializer.
interface demux7_deserializer_if #(
  parameter int unsigned NSLOTS = 7
);
  logic              DataIn;
  logic              InValid;
  logic              Sync;
  logic [NSLOTS-1:0] DemuxOut;
  logic              OutValid;
  logic [2:0]        SlotSel;
  logic              Busy;
  logic              ParityErr;

  modport master (
    output DataIn, InValid, Sync,
    input  DemuxOut, OutValid, SlotSel, Busy, ParityErr
  );

  modport slave (
    input  DataIn, InValid, Sync,
    output DemuxOut, OutValid, SlotSel, Busy, ParityErr
  );
endinterface

// File: rtl/demux7_deserializer.sv
// Steers one serial bit per valid cycle into slot 0..NSLOTS-1 of a parallel word.
// Optional trailing even-parity bit (slot code 3'b111) enabled by PARITY_CHECK_EN.
module demux7_deserializer #(
  parameter int unsigned NSLOTS = 7
) (
  input logic                  Clock,
  input logic                  Resetn,
  demux7_deserializer_if.slave bus
);

`ifdef PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, COLLECT} state_t;
`endif

  localparam logic [2:0] SLOT_IDLE = 3'b111;
  localparam logic [2:0] SLOT_LAST = 3'(NSLOTS - 1);

  state_t            state;
  logic [2:0]        slot_sel;
  logic [NSLOTS-1:0] shadow;
  logic [NSLOTS-1:0] merged;
  logic [NSLOTS-1:0] demux_out;
  logic              out_valid;

  // Shadow word with the current bit written into the slot being filled.
  always_comb begin
    merged = shadow;
    for (int unsigned k = 0; k < NSLOTS; k++) begin
      if (slot_sel == 3'(k)) merged[k] = bus.DataIn;
    end
  end

`ifdef PARITY_CHECK_EN
  logic parity_err;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state     <= IDLE;
      slot_sel  <= SLOT_IDLE;
      shadow    <= '0;
      demux_out <= '0;
      out_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      if (bus.InValid) begin
        // Sync restarts from any state; a partial frame is simply dropped.
        if (bus.Sync) begin
          shadow    <= {{(NSLOTS-1){1'b0}}, bus.DataIn};
          slot_sel  <= 3'd1;
          state     <= COLLECT;
        end else begin
          case (state)
            COLLECT: begin
              if (slot_sel == SLOT_LAST) begin
                slot_sel <= SLOT_IDLE;
`ifdef PARITY_CHECK_EN
                shadow   <= merged;
                state    <= PARITY;
`else
                demux_out <= merged;
                out_valid <= 1'b1;
                state     <= IDLE;
`endif
              end else begin
                shadow   <= merged;
                slot_sel <= slot_sel + 3'd1;
              end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
              demux_out  <= shadow;
              out_valid  <= 1'b1;
              parity_err <= (^shadow) ^ bus.DataIn;
              state      <= IDLE;
            end
`endif
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.DemuxOut = demux_out;
  assign bus.OutValid = out_valid;
  assign bus.SlotSel  = slot_sel;
  assign bus.Busy     = (state != IDLE);
`ifdef PARITY_CHECK_EN
  assign bus.ParityErr = parity_err;
`else
  assign bus.ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_demux7_deserializer.sv
// Directed-vector bench for demux7_deserializer; expectations are hand-computed.
// Also covers the PARITY_CHECK_EN build when that macro is defined.
module tb_demux7_deserializer;

  logic Clock;
  logic Resetn;
  int unsigned errors;
  int unsigned checks;
  int unsigned pulses;

  demux7_deserializer_if #(.NSLOTS(7)) bus ();

  demux7_deserializer #(.NSLOTS(7)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(negedge Clock) if (bus.OutValid) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic d);
    @(negedge Clock);
    bus.InValid = v;
    bus.Sync    = s;
    bus.DataIn  = d;
  endtask

  task automatic send_bits(input logic [6:0] w, input int unsigned first, input int unsigned last);
    for (int unsigned i = first; i <= last; i++) drive(1'b1, i == 0, w[i]);
  endtask

  // Trailing parity bit (even parity) only exists in the parity build.
  task automatic send_tail(input logic [6:0] w);
`ifdef PARITY_CHECK_EN
    drive(1'b1, 1'b0, ^w);
`endif
  endtask

  task automatic expect_frame(input string tag, input logic [6:0] w);
    drive(1'b0, 1'b0, 1'b0);
    check({tag, "_valid"}, 32'(bus.OutValid), 32'd1);
    check({tag, "_data"}, 32'(bus.DemuxOut), 32'(w));
    drive(1'b0, 1'b0, 1'b0);
    check({tag, "_pulse_end"}, 32'(bus.OutValid), 32'd0);
    check({tag, "_hold"}, 32'(bus.DemuxOut), 32'(w));
  endtask

  int unsigned p0;

  initial begin
    errors = 0; checks = 0; pulses = 0;
    Resetn = 1'b0;
    bus.InValid = 1'b0; bus.Sync = 1'b0; bus.DataIn = 1'b0;
    repeat (2) @(negedge Clock);
    check("rst_slot", 32'(bus.SlotSel), 32'd7);
    check("rst_busy", 32'(bus.Busy), 32'd0);
    check("rst_out", 32'(bus.DemuxOut), 32'd0);
    check("rst_valid", 32'(bus.OutValid), 32'd0);
    check("rst_perr", 32'(bus.ParityErr), 32'd0);
    Resetn = 1'b1;

    // T1: async reset mid-frame
    send_bits(7'b1111111, 0, 2);
    @(posedge Clock); #3;
    check("t1_busy_pre", 32'(bus.Busy), 32'd1);
    Resetn = 1'b0;
    #1;
    check("t1_slot", 32'(bus.SlotSel), 32'd7);
    check("t1_busy", 32'(bus.Busy), 32'd0);
    check("t1_out", 32'(bus.DemuxOut), 32'd0);
    check("t1_valid", 32'(bus.OutValid), 32'd0);
    p0 = pulses;
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t1_no_pulse_in_rst", 32'(pulses - p0), 32'd0);
    Resetn = 1'b1;
    send_bits(7'b1001101, 0, 6);
    send_tail(7'b1001101);
    expect_frame("t1_frame", 7'b1001101);

    // T2: basic frame, pulse timing
    p0 = pulses;
    send_bits(7'b1001101, 0, 0);
    drive(1'b0, 1'b0, 1'b0);
    check("t2_slot1", 32'(bus.SlotSel), 32'd1);
    check("t2_busy", 32'(bus.Busy), 32'd1);
    send_bits(7'b1001101, 1, 6);
    check("t2_no_early", 32'(bus.OutValid), 32'd0);
    send_tail(7'b1001101);
    expect_frame("t2", 7'b1001101);
    check("t2_slot_idle", 32'(bus.SlotSel), 32'd7);
    check("t2_pulses", 32'(pulses - p0), 32'd1);

    // T3: stall between slots 3 and 4
    send_bits(7'b1001101, 0, 3);
    for (int unsigned i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      check("t3_stall_slot", 32'(bus.SlotSel), 32'd4);
    end
    send_bits(7'b1001101, 4, 6);
    send_tail(7'b1001101);
    expect_frame("t3", 7'b1001101);

    // T4: resync aborts partial frame
    p0 = pulses;
    send_bits(7'b1111111, 0, 3);
    send_bits(7'b0101010, 0, 6);
    send_tail(7'b0101010);
    expect_frame("t4", 7'b0101010);
    check("t4_pulses", 32'(pulses - p0), 32'd1);

    // T5: back-to-back frames, then stray InValid in IDLE
    p0 = pulses;
    send_bits(7'h7F, 0, 6);
    send_tail(7'h7F);
    drive(1'b1, 1'b1, 1'b0);
    check("t5_first_valid", 32'(bus.OutValid), 32'd1);
    check("t5_first_data", 32'(bus.DemuxOut), 32'h7F);
    send_bits(7'h00, 1, 6);
    send_tail(7'h00);
    expect_frame("t5_second", 7'h00);
    check("t5_pulses", 32'(pulses - p0), 32'd2);
    p0 = pulses;
    repeat (3) drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("t5_stray_slot", 32'(bus.SlotSel), 32'd7);
    check("t5_stray_busy", 32'(bus.Busy), 32'd0);
    check("t5_stray_out", 32'(bus.DemuxOut), 32'h00);
    check("t5_stray_pulses", 32'(pulses - p0), 32'd0);

    // T6: parity
`ifdef PARITY_CHECK_EN
    send_bits(7'b1001101, 0, 6);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_valid0", 32'(bus.OutValid), 32'd1);
    check("t6_perr0", 32'(bus.ParityErr), 32'd0);
    send_bits(7'b1001101, 0, 6);
    check("t6_parity_slot", 32'(bus.SlotSel), 32'd6);
    drive(1'b1, 1'b0, 1'b1);
    check("t6_parity_state_slot", 32'(bus.SlotSel), 32'd7);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_valid1", 32'(bus.OutValid), 32'd1);
    check("t6_perr1", 32'(bus.ParityErr), 32'd1);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_perr_hold", 32'(bus.ParityErr), 32'd1);
`else
    send_bits(7'b1001101, 0, 6);
    drive(1'b1, 1'b0, 1'b1);
    check("t6_valid", 32'(bus.OutValid), 32'd1);
    check("t6_perr_tied", 32'(bus.ParityErr), 32'd0);
    drive(1'b0, 1'b0, 1'b0);
    check("t6_perr_tied2", 32'(bus.ParityErr), 32'd0);
    check("t6_idle_slot", 32'(bus.SlotSel), 32'd7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
